// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore-style control FSM for the multi-cycle MIPS core. It sequences the
// shared datapath, register file, ALU and the single unified memory port.
// Supported opcodes: R-type, lw, sw, beq, j, addi.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   opcode             instr[31:26]; stable from DECODE to end of instruction
//   mem_ready          memory completes the current read/write this cycle
//   pc_write           unconditional PC load
//   pc_write_cond      PC load if ALU zero (beq)
//   i_or_d             memory address select: 0=PC, 1=ALUOut
//   mem_read/mem_write memory requests
//   ir_write           load instruction register
//   mem_to_reg         regfile write data: 0=ALUOut, 1=MDR
//   reg_dst            regfile write address: 0=rt, 1=rd
//   reg_write          regfile write enable
//   alu_src_a          0=PC, 1=rs data
//   alu_src_b          00=rt, 01=4, 10=sext imm, 11=sext imm<<2
//   alu_op             00=add, 01=sub, 10=funct-decoded
//   pc_source          00=ALU result, 01=ALUOut, 10=jump target
//   instr_done         one-cycle pulse in the final state of each instruction
//   illegal_op         one-cycle pulse in DECODE for an unsupported opcode
//   state_o            current state (debug)
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EX   = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);

    state_t state_q;
    state_t state_d;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:     state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EX;
                    default:      state_d = FETCH;
                endcase
            end
            MEM_ADDR:  state_d = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
            EXECUTE:   state_d = ALU_WB;
            ADDI_EX:   state_d = ADDI_WB;
            default:   state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Outputs decode straight from the state register rather than from extra
    // output flops: FETCH and MEM_WRITE strobes are gated by the same-cycle
    // mem_ready, and rstn must clear every strobe without waiting for an edge.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        if (rstn) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ;
                        default: begin
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                ALU_WB: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                ADDI_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_o = STATE_W'(state_q);

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style control FSM that sequences the shared datapath, register file, ALU and a single unified memory port for the multi-cycle MIPS core. It replaces the single-cycle main decoder when instruction and data accesses share one memory. The block issues per-state control strobes and stalls on a memory ready handshake. Supported opcodes are R-type, lw, sw, beq, j and addi.

Parameters:
OP_W, 6, opcode field width (instr[31:26])
STATE_W, 4, width of state register and debug state output

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
opcode  in  OP_W  opcode from instruction register; stable from DECODE to end of instruction
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load instruction register
mem_to_reg  out  1  regfile write data: 0=ALUOut, 1=MDR
reg_dst  out  1  regfile write address: 0=rt, 1=rd
reg_write  out  1  regfile write enable
alu_src_a  out  1  0=PC, 1=rs data
alu_src_b  out  2  00=rt data, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  00=add, 01=sub, 10=funct-decoded
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done  out  1  one-cycle pulse in the final state of each instruction
illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
state_o  out  STATE_W  current state (debug)

Behaviour:
- Single clock domain (clk). Reset is asynchronous, active-low (rstn). While rstn=0: state=FETCH and every output is forced to 0, including state_o=0.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11. Codes 12-15 go to FETCH on the next edge with all outputs 0.
- Any output not listed for a state below is 0.
- FETCH: mem_read=1, alu_src_b=01. ir_write=pc_write=mem_ready (gated). Stays in FETCH while mem_ready=0. Goes to DECODE on mem_ready=1.
- DECODE: alu_src_b=11 (branch target precompute). Next state by opcode:
  - 0x00 -> EXECUTE
  - 0x23/0x2B -> MEM_ADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDI_EX
  - any other opcode -> illegal_op=1, instr_done=1, then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Held until mem_ready=1, then MEM_WB.
- MEM_WB: mem_to_reg=1, reg_write=1, instr_done=1. Next state FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Held until mem_ready=1; instr_done=mem_ready. Then FETCH.
- EXECUTE: alu_src_a=1, alu_op=10. Next state ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next state FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10. Next state ADDI_WB.
- ADDI_WB: reg_write=1, instr_done=1. Next state FETCH.
- Zero-wait latencies (FETCH through done): R=4, lw=5, sw=4, beq=3, j=3, addi=4 cycles. Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.
- Reset asserted mid-instruction (e.g. in MEM_WRITE) drops all strobes immediately, without waiting for a clock edge. After release, execution restarts in FETCH.

Test Plan:
- Reset: rstn=0 at any state -> all outputs 0 same cycle. Release with mem_ready=1 -> state_o 0,1 and ir_write=pc_write=1 in FETCH.
- R-type: opcode=0x00, mem_ready=1 -> states 0,1,6,7. alu_op=10 in EXECUTE; reg_dst=1 and reg_write=1 in ALU_WB; instr_done pulses on cycle 4.
- lw with waits: opcode=0x23, mem_ready low 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4. i_or_d=1 in MEM_READ; mem_to_reg=1 and reg_write=1 in MEM_WB; 7 cycles total.
- sw/beq/j: sw (0x2B) -> mem_write=1 only in MEM_WRITE, 4 cycles. beq (0x04) -> pc_write_cond=1, alu_op=01, pc_source=01, 3 cycles. j (0x02) -> pc_write=1, pc_source=10, 3 cycles.
- FETCH stall plus illegal opcode: mem_ready=0 for 3 cycles -> ir_write stays 0. Then opcode=0x3F -> illegal_op=1 in DECODE, back to FETCH, no reg_write or mem_write pulse.
- Async reset in MEM_WRITE: drop rstn between edges -> mem_write falls immediately. After release, state_o=0.
